// File: rtl/if_stage_fq.sv
// if_stage_fq: instruction-fetch stage with a fetch queue.
//
// The pre-IF part issues sequential fetches to a 1-cycle-latency instruction SRAM.
// Each returned {adef, inst, pc} triple is written into an FQ_DEPTH-entry FIFO that feeds decode.
// Issue is credit based: a fetch is only issued when (queued + in-flight) < FQ_DEPTH.
// As a result, SRAM data is never dropped under decode back-pressure.
// A taken branch flushes the queue and the in-flight fetch, and issues at the target in the
// same cycle.
//
// Optional feature: define FS_ADEF_EN to trap misaligned branch targets.
// A misaligned target does not reach the SRAM. Instead a single {adef=1, inst=0, pc=target}
// entry is queued, and fetch halts until the next taken branch.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   ds_allowin       decode accepts the queue head this cycle
//   br_bus           {br_taken, br_target[31:0]}, br_taken is a 1-cycle pulse
//   fs_to_ds_valid   queue head valid toward decode
//   fs_to_ds_bus     {fs_adef, fs_inst[31:0], fs_pc[31:0]} of the queue head
//   inst_sram_*      SRAM request (en/addr) and response (rdata, one cycle after en)
module if_stage_fq #(
  parameter int unsigned FQ_DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic [32:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [64:0] fs_to_ds_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  localparam int unsigned PtrW = $clog2(FQ_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull  = CntW'(FQ_DEPTH);
  localparam logic [CntW:0]   OccLimit = (CntW + 1)'(FQ_DEPTH);

  logic        br_taken;
  logic [31:0] br_target;
  assign br_taken  = br_bus[32];
  assign br_target = br_bus[31:0];

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic            inflight_q, inflight_d;
  logic [31:0]     inflight_pc_q, inflight_pc_d;

  logic [31:0]         fq_inst_q [FQ_DEPTH];
  logic [31:0]         fq_pc_q   [FQ_DEPTH];
  logic [FQ_DEPTH-1:0] fq_adef_q;

  logic        halt;
  logic        adef_pend;
  logic [31:0] adef_pc;
  logic        br_misalign;
  logic [31:0] tgt_addr;

`ifdef FS_ADEF_EN
  logic        halt_q, halt_d;
  logic        adef_pend_q, adef_pend_d;
  logic [31:0] adef_pc_q, adef_pc_d;

  assign br_misalign = br_taken && (br_target[1:0] != 2'b00);
  assign tgt_addr    = br_target;
  assign halt        = halt_q;
  assign adef_pend   = adef_pend_q;
  assign adef_pc     = adef_pc_q;

  // A misaligned branch queues one adef entry next cycle and stops fetch until the next branch.
  always_comb begin
    halt_d      = halt_q;
    adef_pend_d = 1'b0;
    adef_pc_d   = adef_pc_q;
    if (br_taken) begin
      halt_d      = br_misalign;
      adef_pend_d = br_misalign;
      adef_pc_d   = br_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halt_q      <= 1'b0;
      adef_pend_q <= 1'b0;
      adef_pc_q   <= 32'h0;
    end else begin
      halt_q      <= halt_d;
      adef_pend_q <= adef_pend_d;
      adef_pc_q   <= adef_pc_d;
    end
  end
`else
  logic unused_tgt_lsbs;
  assign unused_tgt_lsbs = ^br_target[1:0];
  assign br_misalign     = 1'b0;
  assign tgt_addr        = {br_target[31:2], 2'b00};
  assign halt            = 1'b0;
  assign adef_pend       = 1'b0;
  assign adef_pc         = 32'h0;
`endif

  // Credit check counts the fetch still in flight, so every issued fetch has a free slot.
  logic [CntW:0] occupancy;
  logic          credit_ok;
  assign occupancy = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
  assign credit_ok = occupancy < OccLimit;

  // A branch makes the queue logically empty, so it always has credit.
  logic issue;
  assign issue = !reset && (br_taken ? !br_misalign : (!halt && credit_ok));

  assign inst_sram_en    = issue;
  assign inst_sram_addr  = br_taken ? tgt_addr : fetch_pc_q;
  assign inst_sram_wen   = 4'h0;
  assign inst_sram_wdata = 32'h0;

  logic push_ret, push_adef, push, pop;
  assign push_ret  = inflight_q && !br_taken;
  assign push_adef = adef_pend && !br_taken;
  assign push      = push_ret || push_adef;

  assign fs_to_ds_valid = (count_q != '0) && !br_taken;
  assign pop            = fs_to_ds_valid && ds_allowin;
  assign fs_to_ds_bus   = {fq_adef_q[rd_ptr_q], fq_inst_q[rd_ptr_q], fq_pc_q[rd_ptr_q]};

  always_comb begin
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;

    if (br_taken) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end

    if (issue) begin
      fetch_pc_d    = inst_sram_addr + 32'd4;
      inflight_pc_d = inst_sram_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  // Queue storage needs no reset; count_q qualifies every entry.
  always_ff @(posedge clk) begin
    if (push) begin
      fq_adef_q[wr_ptr_q] <= push_adef;
      fq_inst_q[wr_ptr_q] <= push_adef ? 32'h0 : inst_sram_rdata;
      fq_pc_q[wr_ptr_q]   <= push_adef ? adef_pc : inflight_pc_q;
    end
  end

  // The credit rule must make an overflowing push impossible.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && !pop && (count_q == CntFull)))
        else $error("fetch queue overflow");
    end
  end

endmodule
